// File: rtl/led_breather.sv
// Breathing-LED PWM stage: compares an upstream free-running counter against a
// duty register that ramps up, holds bright, ramps down and holds dark.
module led_breather #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  parameter int unsigned HOLD  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_en,
  output logic             o_led,
  output logic [WIDTH-1:0] o_duty,
  output logic [1:0]       o_state
);

  localparam int unsigned     HW        = $clog2(HOLD + 1);
  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [WIDTH:0]   MAX_W    = {1'b0, MAX};
  localparam logic [WIDTH:0]   STEP_W   = (WIDTH + 1)'(STEP);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_HOLD_HI = 2'd1,
    ST_DOWN    = 2'd2,
    ST_HOLD_LO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] duty_q,  duty_d;
  logic [HW-1:0]    hold_q,  hold_d;
  logic             led_q,   led_d;
  logic             pwrap;
  logic [WIDTH:0]   sum_w;

  assign pwrap = i_en && (i_count == MAX);
  // Extra bit keeps duty+STEP from wrapping before the saturation test.
  assign sum_w = {1'b0, duty_q} + STEP_W;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    led_d   = i_en && (i_count < duty_q);
    if (pwrap) begin
      unique case (state_q)
        ST_UP: begin
          if (sum_w >= MAX_W) begin
            duty_d  = MAX;
            hold_d  = '0;
            state_d = ST_HOLD_HI;
          end else begin
            duty_d = sum_w[WIDTH-1:0];
          end
        end
        ST_HOLD_HI: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = ST_DOWN;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_DOWN: begin
          if ({1'b0, duty_q} <= STEP_W) begin
            duty_d  = '0;
            hold_d  = '0;
            state_d = ST_HOLD_LO;
          end else begin
            duty_d = duty_q - STEP_W[WIDTH-1:0];
          end
        end
        ST_HOLD_LO: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = ST_UP;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = ST_UP;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_UP;
      duty_q  <= '0;
      hold_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign o_led   = led_q;
  assign o_duty  = duty_q;
  assign o_state = state_q;

endmodule

// File: doc/led_breather.md
# led_breather

Breathing-LED PWM stage that sits directly downstream of the free-running parameterised counter. It takes that counter's value as its PWM time base and compares it against an internal duty register to drive the LED. The duty register ramps up, holds at full brightness, ramps down, and holds dark, in a continuous loop. Duty changes happen only at counter wrap boundaries, so every PWM period is glitch-free.

## Interface
- `WIDTH`, 8 — width of the counter input and of the duty register; the PWM period is 2^WIDTH cycles; MAX = 2^WIDTH-1.
- `STEP`, 1 — duty increment/decrement per PWM period; 1 ≤ STEP ≤ MAX.
- `HOLD`, 4 — PWM periods spent in each hold state; HOLD ≥ 1.
- `i_clk` input 1 — the single clock; all state changes on its rising edge.
- `i_reset` input 1 — asynchronous, active-high reset.
- `i_count` input WIDTH — free-running counter value from the upstream counter; it increments by 1 per cycle and wraps.
- `i_en` input 1 — enable; when low, the block freezes and the LED is off.
- `o_led` output 1 — registered PWM output.
- `o_duty` output WIDTH — current duty register.
- `o_state` output 2 — current FSM state: 0 UP, 1 HOLD_HI, 2 DOWN, 3 HOLD_LO.

## Operation
- Period boundary: `pwrap = i_en && (i_count == MAX)`. Duty, state and hold counter change only on cycles where pwrap is high.
- PWM: each cycle, `o_led <= i_en && (i_count < duty)`.
  - duty = 0 gives LED always off.
  - duty = MAX gives LED on for every count except MAX.
- Arithmetic is done in WIDTH+1 bits, with no wrap-around of duty.
- FSM, evaluated on pwrap:
  - UP: `next = duty + STEP`. If next ≥ MAX, set duty = MAX, hold = 0, go to HOLD_HI. Otherwise duty = next.
  - HOLD_HI: if hold == HOLD-1, set hold = 0 and go to DOWN. Otherwise hold++.
  - DOWN: if duty ≤ STEP, set duty = 0, hold = 0, go to HOLD_LO. Otherwise duty -= STEP.
  - HOLD_LO: if hold == HOLD-1, set hold = 0 and go to UP. Otherwise hold++.
- Each hold state therefore lasts exactly HOLD PWM periods.
- The hold counter is $clog2(HOLD+1) bits wide and saturates logically at HOLD-1.
- `i_en` low:
  - o_led goes to 0 on the next edge.
  - Duty, state and hold are frozen, and pwrap is suppressed.
  - When `i_en` returns high, operation resumes from the frozen state; no period is skipped or repeated beyond those lost while disabled.
- Reset (asynchronous, any time including mid-ramp): duty = 0, state = UP, hold = 0, o_led = 0. The first pwrap after reset release performs the first UP step.
- `o_duty` and `o_state` are direct register outputs, with no combinational path from any input.

## Timing
- o_led has 1-cycle latency from i_count.
- A duty update made at the pwrap edge (i_count = MAX) is visible on o_duty in the following cycle, while i_count = 0. It governs o_led starting from the comparison of i_count = 0, which appears on o_led one cycle later.
- o_state changes in the same edge as the duty update.
- If i_count skips MAX (a discontinuous input), no period boundary occurs. The PWM comparison remains valid each cycle.
- Reset values: o_led = 0, o_duty = 0, o_state = 0.

## Test plan
All scenarios use WIDTH=4, STEP=4, HOLD=2, with the upstream counter modelled from 0 after reset.
- Reset, then free-run 192 cycles → o_duty sequence per period is 0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0. o_state follows UP×4, HOLD_HI×2, DOWN×4, HOLD_LO×2, then returns to UP at cycle 192.
- Period with duty = 4 → o_led high for exactly 4 cycles (i_count 0..3, delayed 1 cycle) and low for 12.
- Period with duty = 15 → o_led high for 15 cycles and low for 1. Period with duty = 0 → o_led low for all 16 cycles.
- Drop i_en for 40 cycles during DOWN at duty 11 → o_led is 0 from the next edge. o_duty stays 11 and o_state stays 2. After re-enable, the next pwrap gives duty 7.
- Assert i_reset asynchronously mid-period during HOLD_HI → o_led, o_duty and o_state are 0 immediately, without waiting for a clock edge. After release, the first pwrap gives duty 4.
- STEP=15 variant → duty toggles 0 → 15 in one period and 15 → 0 in one period, with holds intact.
